// File: rtl/ce_seq_ctrl_pkg.sv
// ce_seq_ctrl_pkg: shared definitions for the convolution-engine sequencing
// controller and its result FIFO.
//   - seq_state_t : controller frame state (IDLE, RUN, DRAIN, DONE)
//   - clog2       : count-width helper for FIFO pointers and credit counters
//   - CE_DW_DEF / CE_SR_DEF : default CE result width and result shift,
//                             shared with the CE wrapper
package ce_seq_ctrl_pkg;

  localparam int CE_DW_DEF = 19;
  localparam int CE_SR_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ce_seq_ctrl_if.sv
// ce_seq_ctrl_if: stream signals around the sequencing controller.
//   window side : win_valid (gen -> ctrl), win_ready (ctrl -> gen)
//   CE side     : ce_en_in (ctrl -> CE), ce_en_out / ce_d_out (CE -> ctrl)
//   result side : res_valid / res_data / res_last (ctrl -> writer),
//                 res_ready (writer -> ctrl)
// Modport master is the controller; slave is its environment.
interface ce_seq_ctrl_if
  import ce_seq_ctrl_pkg::*;
#(
  parameter int DW = CE_DW_DEF,
  parameter int SR = CE_SR_DEF
) ();

  logic             win_valid;
  logic             win_ready;
  logic             ce_en_in;
  logic             ce_en_out;
  logic [DW-1:0]    ce_d_out;
  logic             res_valid;
  logic             res_ready;
  logic [DW-SR-1:0] res_data;
  logic             res_last;

  modport master (
    input  win_valid, output win_ready,
    output ce_en_in,  input  ce_en_out, input ce_d_out,
    output res_valid, input  res_ready, output res_data, output res_last
  );

  modport slave (
    output win_valid, input  win_ready,
    input  ce_en_in,  output ce_en_out, output ce_d_out,
    input  res_valid, output res_ready, input res_data, input res_last
  );

endinterface

// File: rtl/ce_res_fifo.sv
// ce_res_fifo: synchronous FIFO holding scaled CE results.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push/din : write request and data; ignored when full without a pop
//   pop/dout : read request; dout is the head entry, valid while !empty
//   count    : number of stored entries (0..DEPTH)
//   full, empty : status flags
// DEPTH must be a power of two so the pointers wrap naturally.
module ce_res_fifo
  import ce_seq_ctrl_pkg::*;
#(
  parameter  int W     = 17,
  parameter  int DEPTH = 8,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;

  // Effective push/pop: a full FIFO still accepts a push when it is popped.
  always_comb begin
    pop_s  = pop & ~empty;
    push_s = push & (~full | pop_s);
  end

  // Storage array, written on an effective push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/ce_seq_ctrl.sv
// ce_seq_ctrl: frame sequencer for one convolution engine (CE).
// Gates windows into the CE under a credit scheme so every in-flight result
// owns a slot in the result FIFO, scales returned results and presents them
// downstream with valid/ready.
//   clk, rst           : clock, asynchronous active-high reset (aborts frame)
//   start              : frame start, honoured only in IDLE
//   cfg_cols, cfg_rows : frame geometry, latched on start
//   busy               : high in RUN and DRAIN
//   done               : one-cycle pulse at end of frame
//   err_ovf            : sticky, result returned with no credit/slot
//   bus (master)       : window, CE and result stream signals
// Build option CE_SEQ_CTRL_RELU_EN: treat CE results as two's complement and
// clamp negative values to zero before scaling.
module ce_seq_ctrl
  import ce_seq_ctrl_pkg::*;
#(
  parameter int DW         = CE_DW_DEF,
  parameter int SR         = CE_SR_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int COLS_W     = 8,
  parameter int ROWS_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [COLS_W-1:0] cfg_cols,
  input  logic [ROWS_W-1:0] cfg_rows,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  ce_seq_ctrl_if.master     bus
);

  localparam int TW = COLS_W + ROWS_W;
  localparam int RW = DW - SR;
  localparam int CW = clog2(FIFO_DEPTH) + 1;

  seq_state_t    state_r;
  seq_state_t    state_s;
  logic [TW-1:0] total_r;
  logic [TW-1:0] issued_r;
  logic [TW-1:0] popped_r;
  logic [CW-1:0] outstanding_r;
  logic          err_ovf_r;

  logic [TW-1:0] frame_total_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [RW-1:0] fifo_dout_s;
  logic [RW-1:0] scaled_s;
  logic          credit_s;
  logic          win_ready_s;
  logic          issue_s;
  logic          pop_s;
  logic          ret_ok_s;
  logic          push_s;
  logic          drop_s;
  logic          last_s;

  // Issue/return/pop qualification. Credits count results already owed by
  // the CE plus results sitting in the FIFO.
  always_comb begin
    frame_total_s = TW'(cfg_cols) * TW'(cfg_rows);
    credit_s      = ({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < (CW + 1)'(FIFO_DEPTH);
    win_ready_s   = (state_r == RUN) & (issued_r < total_r) & credit_s;
    issue_s       = bus.win_valid & win_ready_s;
    pop_s         = ~fifo_empty_s & bus.res_ready;
    last_s        = ~fifo_empty_s & (popped_r == total_r - TW'(1'b1));
    ret_ok_s      = bus.ce_en_out & (outstanding_r != {CW{1'b0}});
    push_s        = ret_ok_s & (~fifo_full_s | pop_s);
    drop_s        = bus.ce_en_out & ~push_s;
  end

  // Result scaling applied before the FIFO.
  always_comb begin
`ifdef CE_SEQ_CTRL_RELU_EN
    // Arithmetic shift of a non-negative value equals the plain slice.
    if (bus.ce_d_out[DW-1]) begin
      scaled_s = {RW{1'b0}};
    end else begin
      scaled_s = bus.ce_d_out[DW-1:SR];
    end
`else
    scaled_s = bus.ce_d_out[DW-1:SR];
`endif
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (frame_total_s != {TW{1'b0}}) ? RUN : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if ((issued_r == total_r) || (issue_s && (issued_r + TW'(1'b1) == total_r))) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if ((popped_r == total_r) || (pop_s && (popped_r + TW'(1'b1) == total_r))) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Frame size latch and issued/popped counters, restarted on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_r  <= {TW{1'b0}};
      issued_r <= {TW{1'b0}};
      popped_r <= {TW{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      total_r  <= frame_total_s;
      issued_r <= {TW{1'b0}};
      popped_r <= {TW{1'b0}};
    end else begin
      if (issue_s) issued_r <= issued_r + TW'(1'b1);
      if (pop_s)   popped_r <= popped_r + TW'(1'b1);
    end
  end

  // Results owed by the CE; a same-cycle issue and return cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_r <= {CW{1'b0}};
    end else begin
      case ({issue_s, ret_ok_s})
        2'b10:   outstanding_r <= outstanding_r + CW'(1'b1);
        2'b01:   outstanding_r <= outstanding_r - CW'(1'b1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Sticky overflow flag for dropped results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_ovf_r <= 1'b0;
    else if (drop_s) err_ovf_r <= 1'b1;
    else             err_ovf_r <= err_ovf_r;
  end

  ce_res_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (scaled_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign bus.win_ready = win_ready_s;
  assign bus.ce_en_in  = issue_s;
  assign bus.res_valid = ~fifo_empty_s;
  assign bus.res_data  = fifo_dout_s;
  assign bus.res_last  = last_s;
  assign busy          = (state_r == RUN) | (state_r == DRAIN);
  assign done          = (state_r == DONE);
  assign err_ovf       = err_ovf_r;

endmodule

// File: tb/tb_ce_seq_ctrl.sv
// Self-checking bench for ce_seq_ctrl: a CE latency model, a queue-based
// result scoreboard, a scaling vector table, directed corner sequences and
// randomized frames.
module tb_ce_seq_ctrl;

  localparam int DW    = 19;
  localparam int SR    = 2;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cfg_cols = 8'd0;
  logic [7:0] cfg_rows = 8'd0;
  logic       busy;
  logic       done;
  logic       err_ovf;

  ce_seq_ctrl_if #(.DW(DW), .SR(SR)) bus ();

  ce_seq_ctrl #(
    .DW(DW), .SR(SR), .FIFO_DEPTH(DEPTH), .COLS_W(8), .ROWS_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .busy(busy), .done(done), .err_ovf(err_ovf), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc = 0, issue_cnt = 0, pop_cnt = 0, done_cnt = 0;
  int done_cyc = 0, last_pop_cyc = 0, max_inflight = 0, frame_total = 0;
  int lat = 4;
  bit ce_manual = 1'b0;
  bit rnd_mode  = 1'b0;
  logic [18:0] ce_data_q[$];
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  logic        pv[8];
  logic [18:0] pd[8];

  typedef struct packed {
    logic [18:0] din;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Expected result from the raw CE word: divide by 2**SR, clamp negatives
  // to zero when the ReLU build is selected.
  function automatic logic [16:0] ref_scale(input logic [18:0] d);
`ifdef CE_SEQ_CTRL_RELU_EN
    if (d >= 19'h40000) return 17'd0;
`endif
    return 17'(d / 19'd4);
  endfunction

  // CE model + scoreboard, evaluated on the falling edge.
  initial begin
    logic [18:0] d;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        for (int i = 0; i < 8; i++) pv[i] = 1'b0;
        if (!ce_manual) bus.ce_en_out = 1'b0;
      end else begin
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("res_data", 32'(bus.res_data), 32'(e));
          end
          chk("res_last", 32'(bus.res_last), 32'(pop_cnt == frame_total - 1));
          got_q.push_back(bus.res_data);
          pop_cnt++;
          last_pop_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        d = 19'd0;
        if (bus.ce_en_in) begin
          d = (ce_data_q.size() > 0) ? ce_data_q.pop_front() : 19'($urandom);
          issue_cnt++;
          exp_q.push_back(ref_scale(d));
        end
        if (issue_cnt - pop_cnt > max_inflight) max_inflight = issue_cnt - pop_cnt;
        if (!ce_manual) begin
          for (int i = 7; i > 0; i--) begin
            if (i < lat) begin
              pv[i] = pv[i-1];
              pd[i] = pd[i-1];
            end
          end
          pv[0] = bus.ce_en_in;
          pd[0] = d;
          bus.ce_en_out = pv[lat-1];
          bus.ce_d_out  = pd[lat-1];
        end
      end
    end
  end

  task automatic start_frame(input int c, input int r);
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    issue_cnt = 0; pop_cnt = 0; done_cnt = 0; max_inflight = 0;
    for (int i = 0; i < 8; i++) pv[i] = 1'b0;
    frame_total = c * r;
    cfg_cols = 8'(c);
    cfg_rows = 8'(r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      @(posedge clk); #1;
      if (rnd_mode) begin
        bus.win_valid = ($urandom_range(0, 3) != 0);
        bus.res_ready = ($urandom_range(0, 2) != 0);
      end
    end
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic finish_checks();
    @(posedge clk); #1;
    chk("issue_count", 32'(issue_cnt), 32'(frame_total));
    chk("result_count", 32'(pop_cnt), 32'(frame_total));
    chk("results_pending", 32'(exp_q.size()), 32'd0);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    if (frame_total > 0) chk("done_after_last_pop", 32'(done_cyc), 32'(last_pop_cyc + 1));
    chk("credit_bound", 32'(max_inflight <= DEPTH), 32'd1);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("err_ovf_clean", 32'(err_ovf), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_win_ready"}, 32'(bus.win_ready), 32'd0);
    chk({tag, "_ce_en_in"}, 32'(bus.ce_en_in), 32'd0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_res_last"}, 32'(bus.res_last), 32'd0);
    chk({tag, "_err_ovf"}, 32'(err_ovf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, r;
    tbl[0] = '{19'h0004C, 17'd19};
    tbl[1] = '{19'h00007, 17'd1};
    tbl[2] = '{19'h00003, 17'd0};
    tbl[3] = '{19'h3FFFF, 17'h0FFFF};
`ifdef CE_SEQ_CTRL_RELU_EN
    tbl[4] = '{19'h7FFFF, 17'd0};
    tbl[5] = '{19'h40000, 17'd0};
`else
    tbl[4] = '{19'h7FFFF, 17'h1FFFF};
    tbl[5] = '{19'h40000, 17'h10000};
`endif
    bus.win_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.ce_en_out = 1'b0;
    bus.ce_d_out  = 19'd0;

    // Reset state.
    @(posedge clk); #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 3x2 frame, always valid/ready, CE latency 4.
    lat = 4;
    bus.win_valid = 1'b1;
    bus.res_ready = 1'b1;
    start_frame(3, 2);
    chk("busy_in_run", 32'(busy), 32'd1);
    wait_done(200);
    finish_checks();

    // Downstream stalled: credits cap issue at FIFO depth.
    bus.res_ready = 1'b0;
    start_frame(5, 4);
    repeat (40) begin @(posedge clk); #1; end
    chk("stall_issue_cap", 32'(issue_cnt), 32'd8);
    chk("stall_win_ready", 32'(bus.win_ready), 32'd0);
    chk("stall_res_valid", 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1;
    wait_done(400);
    finish_checks();

    // Scaling vector table.
    lat = 3;
    for (int i = 0; i < 6; i++) ce_data_q.push_back(tbl[i].din);
    start_frame(6, 1);
    wait_done(200);
    finish_checks();
    chk("table_size", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) chk("table_res_data", 32'(got_q[i]), 32'(tbl[i].exp));
    end

    // Empty frame goes straight to DONE.
    start_frame(0, 5);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("zero_done_width", 32'(done), 32'd0);
    chk("zero_issue", 32'(issue_cnt), 32'd0);
    chk("zero_done_pulses", 32'(done_cnt), 32'd1);

    // Reset after 3 of 10 issues, then a clean 4-window frame.
    lat = 4;
    start_frame(10, 1);
    for (int k = 0; k < 50 && issue_cnt < 3; k++) begin @(posedge clk); #1; end
    chk("abort_issue_reached", 32'(issue_cnt), 32'd3);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b0;
    start_frame(4, 1);
    wait_done(200);
    finish_checks();

    // Randomized frames.
    rnd_mode = 1'b1;
    for (int f = 0; f < 8; f++) begin
      c   = $urandom_range(1, 4);
      r   = $urandom_range(1, 5);
      lat = $urandom_range(2, 6);
      start_frame(c, r);
      wait_done(3000);
      finish_checks();
    end
    rnd_mode = 1'b0;
    bus.win_valid = 1'b0;
    bus.res_ready = 1'b1;

    // Spurious CE return while idle.
    ce_manual = 1'b1;
    @(posedge clk); #1;
    bus.ce_en_out = 1'b1;
    bus.ce_d_out  = 19'h0004C;
    @(posedge clk); #1;
    bus.ce_en_out = 1'b0;
    chk("spurious_err_ovf", 32'(err_ovf), 32'd1);
    chk("spurious_res_valid", 32'(bus.res_valid), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("spurious_err_sticky", 32'(err_ovf), 32'd1);
    chk("spurious_res_valid_later", 32'(bus.res_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("err_ovf_cleared_by_rst", 32'(err_ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ce_manual = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
